// File: rtl/fpaa_prog_shifter_if.sv
// rtl/fpaa_prog_shifter_if.sv - command bus between config loader and FPAA programming shifter
// Purpose: groups the one-command-at-a-time valid/ready handshake and its payload.
// Signals:
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  shifter can accept
//   cmd_col    master->slave  target CAB column
//   cmd_mrow   master->slave  switch-matrix row
//   cmd_mcol   master->slave  switch-matrix column
//   cmd_data   master->slave  cell configuration value
interface fpaa_prog_shifter_if #(
  parameter int COL_W  = 3,
  parameter int MR_W   = 3,
  parameter int MC_W   = 1,
  parameter int DATA_W = 8
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [COL_W-1:0]  cmd_col;
  logic [MR_W-1:0]   cmd_mrow;
  logic [MC_W-1:0]   cmd_mcol;
  logic [DATA_W-1:0] cmd_data;

  modport master (
    output cmd_valid, cmd_col, cmd_mrow, cmd_mcol, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_col, cmd_mrow, cmd_mcol, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/fpaa_prog_shifter.sv
// rtl/fpaa_prog_shifter.sv - serializes FPAA configuration commands onto an island programming chain
// Purpose: accepts one command, range-checks it, shifts {mrow, mcol, data[, parity]} MSB first
//   with a divided shift clock, strobes the latch, waits the settle time, then pulses done.
// Optional feature macro: PROG_PARITY_EN appends one even-parity bit after the data LSB.
// Ports:
//   clk           sole clock
//   rst_n         asynchronous active-low reset
//   cmd           fpaa_prog_shifter_if.slave command handshake (cmd_ready registered, reset 1)
//   o_prog_sclk   shift clock to fabric
//   o_prog_sdata  serial data, MSB first
//   o_prog_latch  latch strobe
//   o_prog_sel    one-hot column select, held for the whole transfer
//   o_done        one-cycle completion pulse
//   o_err         one-cycle out-of-range pulse
module fpaa_prog_shifter #(
  parameter int NUM_COLS    = 7,
  parameter int MATRIX_ROWS = 7,
  parameter int MATRIX_COLS = 1,
  parameter int DATA_W      = 8,
  parameter int CLK_DIV     = 2,
  parameter int SETTLE_CYC  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  fpaa_prog_shifter_if.slave  cmd,
  output logic                o_prog_sclk,
  output logic                o_prog_sdata,
  output logic                o_prog_latch,
  output logic [NUM_COLS-1:0] o_prog_sel,
  output logic                o_done,
  output logic                o_err
);

  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int MR_W  = (MATRIX_ROWS > 1) ? $clog2(MATRIX_ROWS) : 1;
  localparam int MC_W  = (MATRIX_COLS > 1) ? $clog2(MATRIX_COLS) : 1;
`ifdef PROG_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int FRAME = MR_W + MC_W + DATA_W + PAR_W;
  localparam int BIT_W = $clog2(FRAME);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  // One extra bit so a limit equal to 2**W still fits for the >= compare.
  localparam logic [COL_W:0] LP_COL_LIM  = (COL_W + 1)'(NUM_COLS);
  localparam logic [MR_W:0]  LP_MROW_LIM = (MR_W + 1)'(MATRIX_ROWS);
  localparam logic [MC_W:0]  LP_MCOL_LIM = (MC_W + 1)'(MATRIX_COLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH,
    S_SETTLE,
    S_ERR
  } state_t;

  state_t              r_state;
  // MSB of the frame goes straight to r_sdata at accept, so only the tail is stored.
  logic [FRAME-2:0]    r_frame;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [SET_W-1:0]    r_set_cnt;
  logic                r_ready;
  logic                r_sclk;
  logic                r_sdata;
  logic                r_latch;
  logic [NUM_COLS-1:0] r_sel;
  logic                r_done;
  logic                r_err;

  logic                w_accept;
  logic                w_range_err;
  logic [FRAME-1:0]    w_frame_in;
  logic [NUM_COLS-1:0] w_sel_onehot;
  logic                w_div_last;
  logic                w_set_last;
  logic                w_bit_last;

  assign w_accept    = cmd.cmd_valid && r_ready;
  assign w_range_err = ({1'b0, cmd.cmd_col}  >= LP_COL_LIM)  ||
                       ({1'b0, cmd.cmd_mrow} >= LP_MROW_LIM) ||
                       ({1'b0, cmd.cmd_mcol} >= LP_MCOL_LIM);

`ifdef PROG_PARITY_EN
  assign w_frame_in = {cmd.cmd_mrow, cmd.cmd_mcol, cmd.cmd_data,
                       ^{cmd.cmd_mrow, cmd.cmd_mcol, cmd.cmd_data}};
`else
  assign w_frame_in = {cmd.cmd_mrow, cmd.cmd_mcol, cmd.cmd_data};
`endif

  assign w_sel_onehot = NUM_COLS'(1) << cmd.cmd_col;
  assign w_div_last   = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_set_last   = (r_set_cnt == SET_W'(SETTLE_CYC - 1));
  assign w_bit_last   = (r_bit_cnt == BIT_W'(FRAME - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_frame   <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_set_cnt <= '0;
      r_ready   <= 1'b1;
      r_sclk    <= 1'b0;
      r_sdata   <= 1'b0;
      r_latch   <= 1'b0;
      r_sel     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            if (w_range_err) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              // First low phase starts right away with the MSB already on sdata.
              r_state   <= S_SHIFT;
              r_sel     <= w_sel_onehot;
              r_frame   <= w_frame_in[FRAME-2:0];
              r_sdata   <= w_frame_in[FRAME-1];
              r_sclk    <= 1'b0;
              r_div_cnt <= '0;
              r_bit_cnt <= '0;
            end
          end
        end

        S_SHIFT: begin
          if (w_div_last) begin
            r_div_cnt <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              // End of high phase: sdata only moves here, i.e. at the start of a low phase.
              r_sclk <= 1'b0;
              if (w_bit_last) begin
                r_state <= S_LATCH;
                r_latch <= 1'b1;
                r_sdata <= 1'b0;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_sdata   <= r_frame[FRAME-2];
                r_frame   <= {r_frame[FRAME-3:0], 1'b0};
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end

        S_LATCH: begin
          if (w_div_last) begin
            r_div_cnt <= '0;
            r_latch   <= 1'b0;
            r_set_cnt <= '0;
            r_state   <= S_SETTLE;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end

        S_SETTLE: begin
          if (w_set_last) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
          end else begin
            r_set_cnt <= r_set_cnt + 1'b1;
          end
        end

        S_ERR: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end

        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign cmd.cmd_ready = r_ready;
  assign o_prog_sclk   = r_sclk;
  assign o_prog_sdata  = r_sdata;
  assign o_prog_latch  = r_latch;
  assign o_prog_sel    = r_sel;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

// File: tb/tb_fpaa_prog_shifter.sv
// tb/tb_fpaa_prog_shifter.sv - self-checking bench for fpaa_prog_shifter
module tb_fpaa_prog_shifter;

  localparam int CLK_DIV    = 2;
  localparam int SETTLE_CYC = 4;
`ifdef PROG_PARITY_EN
  localparam int FRAME = 13;
`else
  localparam int FRAME = 12;
`endif
  localparam int LATCH_FIRST = 1 + FRAME * 2 * CLK_DIV;
  localparam int DONE_CYC    = LATCH_FIRST + CLK_DIV + SETTLE_CYC;
  localparam int NVEC        = 7;

  typedef struct {
    logic [2:0]  col;
    logic [2:0]  mrow;
    logic        mcol;
    logic [7:0]  data;
    bit          exp_err;
    logic [6:0]  exp_sel;
    logic [11:0] exp_bits;
    bit          exp_par;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       sclk, sdata, latch, done, err;
  logic [6:0] sel;

  int total = 0;
  int bad   = 0;

  vec_t vecs [NVEC];

  int          m_nbits, m_latch_first, m_latch_cnt, m_done_cyc, m_glitch, m_ready_busy;
  logic [15:0] m_bits;
  logic [6:0]  m_sel_c1, m_sel_pre, m_sel_done;
  logic        m_ready_c1, m_ready_c2, m_err_c1, m_err_c2, m_ready_done;

  fpaa_prog_shifter_if #(.COL_W(3), .MR_W(3), .MC_W(1), .DATA_W(8)) bus ();

  fpaa_prog_shifter u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (bus),
    .o_prog_sclk  (sclk),
    .o_prog_sdata (sdata),
    .o_prog_latch (latch),
    .o_prog_sel   (sel),
    .o_done       (done),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic issue(input vec_t v, input bit hold);
    @(negedge clk);
    bus.cmd_col   = v.col;
    bus.cmd_mrow  = v.mrow;
    bus.cmd_mcol  = v.mcol;
    bus.cmd_data  = v.data;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  // Watches cycles 1..limit after the accepting edge, stopping early at done.
  task automatic observe(input int limit);
    logic prev_sclk, prev_sdata;
    prev_sclk = 1'b0; prev_sdata = 1'b0;
    m_nbits = 0; m_latch_first = 0; m_latch_cnt = 0; m_done_cyc = 0;
    m_glitch = 0; m_ready_busy = 0; m_bits = '0;
    m_sel_c1 = '0; m_sel_pre = '0; m_sel_done = '0;
    m_ready_c1 = 1'b0; m_ready_c2 = 1'b0; m_err_c1 = 1'b0; m_err_c2 = 1'b0; m_ready_done = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (c == 1) begin m_sel_c1 = sel; m_ready_c1 = bus.cmd_ready; m_err_c1 = err; end
      if (c == 2) begin m_ready_c2 = bus.cmd_ready; m_err_c2 = err; end
      if (c == DONE_CYC - 1) m_sel_pre = sel;
      if (sclk && !prev_sclk) begin m_bits = {m_bits[14:0], sdata}; m_nbits++; end
      if (sclk && prev_sclk && (sdata !== prev_sdata)) m_glitch++;
      if (latch) begin
        if (m_latch_cnt == 0) m_latch_first = c;
        m_latch_cnt++;
      end
      if (done) begin
        m_done_cyc = c; m_sel_done = sel; m_ready_done = bus.cmd_ready;
      end else if (bus.cmd_ready) begin
        m_ready_busy++;
      end
      prev_sclk = sclk; prev_sdata = sdata;
      if (m_done_cyc != 0) break;
    end
  endtask

  function automatic logic [15:0] exp_frame(input vec_t v);
    logic [15:0] eb;
    eb = {4'b0, v.exp_bits};
`ifdef PROG_PARITY_EN
    eb = {eb[14:0], v.exp_par};
`endif
    return eb;
  endfunction

  task automatic check_valid(input string tag, input vec_t v);
    check({tag, "_sel_c1"},     32'(m_sel_c1), 32'(v.exp_sel));
    check({tag, "_ready_c1"},   32'(m_ready_c1), 32'd0);
    check({tag, "_nbits"},      32'(m_nbits), 32'(FRAME));
    check({tag, "_bits"},       32'(m_bits), 32'(exp_frame(v)));
    check({tag, "_sdata_hold"}, 32'(m_glitch), 32'd0);
    check({tag, "_latch_first"},32'(m_latch_first), 32'(LATCH_FIRST));
    check({tag, "_latch_len"},  32'(m_latch_cnt), 32'(CLK_DIV));
    check({tag, "_done_cyc"},   32'(m_done_cyc), 32'(DONE_CYC));
    check({tag, "_sel_settle"}, 32'(m_sel_pre), 32'(v.exp_sel));
    check({tag, "_sel_done"},   32'(m_sel_done), 32'd0);
    check({tag, "_ready_done"}, 32'(m_ready_done), 32'd1);
    check({tag, "_ready_busy"}, 32'(m_ready_busy), 32'd0);
  endtask

  initial begin
    int lat_seen;
    vecs[0] = '{3'd3, 3'd5, 1'b0, 8'hA5, 1'b0, 7'h08, 12'b101_0_10100101, 1'b0};
    vecs[1] = '{3'd0, 3'd0, 1'b0, 8'hFF, 1'b0, 7'h01, 12'b000_0_11111111, 1'b0};
    vecs[2] = '{3'd6, 3'd6, 1'b0, 8'h01, 1'b0, 7'h40, 12'b110_0_00000001, 1'b1};
    vecs[3] = '{3'd7, 3'd0, 1'b0, 8'h12, 1'b1, 7'h00, 12'h000,           1'b0};
    vecs[4] = '{3'd2, 3'd7, 1'b0, 8'h34, 1'b1, 7'h00, 12'h000,           1'b0};
    vecs[5] = '{3'd1, 3'd3, 1'b1, 8'h56, 1'b1, 7'h00, 12'h000,           1'b0};
    vecs[6] = '{3'd5, 3'd2, 1'b0, 8'h3C, 1'b0, 7'h20, 12'b010_0_00111100, 1'b1};

    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_col = '0; bus.cmd_mrow = '0; bus.cmd_mcol = '0; bus.cmd_data = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({bus.cmd_ready, sclk, sdata, latch, sel, done, err}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0}));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i], 1'b0);
      if (vecs[i].exp_err) begin
        observe(3);
        check($sformatf("v%0d_err_c1", i),   32'(m_err_c1), 32'd1);
        check($sformatf("v%0d_ready_c1", i), 32'(m_ready_c1), 32'd0);
        check($sformatf("v%0d_err_c2", i),   32'(m_err_c2), 32'd0);
        check($sformatf("v%0d_ready_c2", i), 32'(m_ready_c2), 32'd1);
        check($sformatf("v%0d_no_sclk", i),  32'(m_nbits), 32'd0);
        check($sformatf("v%0d_no_latch", i), 32'(m_latch_cnt), 32'd0);
        check($sformatf("v%0d_no_sel", i),   32'(m_sel_c1), 32'd0);
      end else begin
        observe(DONE_CYC + 20);
        check_valid($sformatf("v%0d", i), vecs[i]);
      end
    end

    // Back-to-back: valid held throughout, payload switched after the first accept.
    issue(vecs[0], 1'b1);
    bus.cmd_col = vecs[2].col; bus.cmd_mrow = vecs[2].mrow;
    bus.cmd_mcol = vecs[2].mcol; bus.cmd_data = vecs[2].data;
    observe(DONE_CYC + 20);
    check_valid("b2b_a", vecs[0]);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    observe(DONE_CYC + 20);
    check_valid("b2b_b", vecs[2]);

    // Reset in the middle of a frame.
    issue(vecs[1], 1'b0);
    lat_seen = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (latch) lat_seen++;
    end
    check("rst_pre_sel", 32'(sel), 32'h01);
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", 32'({bus.cmd_ready, sclk, sdata, latch, sel, done, err}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0}));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (latch) lat_seen++;
    end
    check("rst_no_latch", 32'(lat_seen), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(vecs[0], 1'b0);
    observe(DONE_CYC + 20);
    check_valid("post_rst", vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpaa_prog_shifter.md
# fpaa_prog_shifter

Programming-side transmitter for an FPAA island's programming mux. Accepts one configuration command at a time (target CAB column, switch-matrix row/column, data word), serializes it onto the island's programming chain with a divided shift clock, and drives the one-hot column select, latch strobe and settle wait the fabric needs before the next word. Sits between the host/config loader and the fabric top-level programming mux; one instance per island.

## Interface
- NUM_COLS, 7, CAB columns in the island row
- MATRIX_ROWS, 7, switch-matrix rows per CAB
- MATRIX_COLS, 1, switch-matrix columns per CAB
- DATA_W, 8, configuration data bits per switch cell
- CLK_DIV, 2, clk cycles per prog_sclk half-period (>=1)
- SETTLE_CYC, 4, clk cycles to wait after latch (>=1)
- Derived: COL_W=max(1,clog2(NUM_COLS)), MR_W=max(1,clog2(MATRIX_ROWS)), MC_W=max(1,clog2(MATRIX_COLS)), FRAME=MR_W+MC_W+DATA_W (+1 with parity)

- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept; reset 1
- cmd_col  in  COL_W  target CAB column
- cmd_mrow  in  MR_W  switch-matrix row
- cmd_mcol  in  MC_W  switch-matrix column
- cmd_data  in  DATA_W  cell configuration value
- prog_sclk  out  1  shift clock to fabric; reset 0
- prog_sdata  out  1  serial data, MSB first; reset 0
- prog_latch  out  1  latch strobe; reset 0
- prog_sel  out  NUM_COLS  one-hot column select; reset 0
- done  out  1  one-cycle completion pulse; reset 0
- err  out  1  one-cycle out-of-range pulse; reset 0

## Operation
- States: IDLE, SHIFT, LATCH, SETTLE, ERR.
- IDLE: cmd_ready=1, prog_sel=0. cmd_valid&&cmd_ready accepts; fields captured into frame register {mrow, mcol, data[, parity]}.
- Range check at accept: cmd_col>=NUM_COLS, cmd_mrow>=MATRIX_ROWS or cmd_mcol>=MATRIX_COLS -> ERR. ERR lasts one cycle: err=1, cmd_ready=0, no sclk/latch/sel activity; then IDLE.
- Valid command -> SHIFT; prog_sel=one-hot(cmd_col), held through SHIFT, LATCH, SETTLE.
- SHIFT: each bit occupies 2*CLK_DIV cycles: CLK_DIV cycles sclk=0, then CLK_DIV cycles sclk=1; sdata changes only at start of the low phase, stable across the rising edge. Bit counter counts FRAME bits, MSB first.
- LATCH: sclk=0, prog_latch=1 for CLK_DIV cycles.
- SETTLE: SETTLE_CYC cycles, all strobes low, sel still held.
- Exit SETTLE -> IDLE; done=1 and cmd_ready=1 in that first IDLE cycle, prog_sel=0.
- cmd_valid while busy is ignored (cmd_ready=0); inputs need only be stable at the accepting edge.
- Async reset mid-frame: all outputs to reset values immediately, FSM to IDLE; no latch issued, so fabric discards partial frame.

## Timing
- Cycle k = k clk edges after the accepting edge.
- SHIFT: cycles 1..FRAME*2*CLK_DIV. LATCH: next CLK_DIV cycles. SETTLE: next SETTLE_CYC cycles.
- done/cmd_ready high at cycle 1+FRAME*2*CLK_DIV+CLK_DIV+SETTLE_CYC. Defaults (FRAME=12): shift 1..48, latch 49..50, settle 51..54, done at 55.
- Back-to-back: next command may be accepted in the done cycle.
- ERR: err high at cycle 1, cmd_ready high at cycle 2.
- All outputs registered; no combinational input-to-output paths except none.

## Configuration
- PROG_PARITY_EN defined: one even-parity bit over mrow, mcol and data appended after data LSB; FRAME increases by 1 (default 13, done at cycle 59).
- Undefined: no parity bit; FRAME=MR_W+MC_W+DATA_W.

## Test plan
- Reset: rst_n=0 -> cmd_ready=1, sclk/sdata/latch/sel/done/err=0.
- Defaults, col=3, mrow=5, mcol=0, data=0xA5 -> sel=0x08, sdata bits 1,0,1,0,1,0,1,0,0,1,0,1 sampled at sclk rises, latch high cycles 49-50, done at 55.
- col=7 (out of range) -> err pulse cycle 1, no sclk edges, cmd_ready=1 at cycle 2.
- Two back-to-back commands (second valid held) -> second accepted in first done cycle, sel switches without gap beyond that cycle.
- rst_n low at cycle 20 -> outputs reset immediately, no latch pulse, fresh command after release completes normally.
- PROG_PARITY_EN, data=0xA5, mrow=5, mcol=0 -> 13th bit=0 (even parity of six 1s), done at cycle 59.
